two_sum_finder: RTL

- Streaming pair-sum detector for the day-1 puzzle class.
- Accepts unsigned values one per cycle over a valid/ready handshake and marks each accepted value in an internal presence bitmap.
- Before marking a value, checks whether its complement (TARGET - value) was already seen; on the first hit, reports both operands and their product.
- Parametrised in data width, target sum and table size. Single pass, no stored input list. Supports restart without reset and end-of-stream "no match" reporting.

---
 rtl/two_sum_finder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/two_sum_finder.sv
// rtl/two_sum_finder.sv - streaming pair-sum detector over a one-bit presence bitmap
module two_sum_finder #(
  parameter int DATA_W   = 16,
  parameter int TARGET   = 2020,
  parameter int TABLE_AW = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data,
  input  logic                data_valid,
  input  logic                data_last,
  output logic                data_ready,
  input  logic                restart,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [DATA_W-1:0]   operand_a,
  output logic [DATA_W-1:0]   operand_b,
  output logic [2*DATA_W-1:0] product,
  output logic [15:0]         beat_count
);

  localparam logic [DATA_W-1:0]   TARGET_W  = DATA_W'(TARGET);
  localparam logic [TABLE_AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TABLE_AW-1:0]   clr_addr_q, clr_addr_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [DATA_W-1:0]     operand_a_q, operand_a_d;
  logic [DATA_W-1:0]     operand_b_q, operand_b_d;
  logic [2*DATA_W-1:0]   product_q, product_d;
  logic [15:0]           beat_count_q, beat_count_d;

  // Presence bitmap: no reset, its contents are only trusted after CLEAR sweeps it.
  logic [(2**TABLE_AW)-1:0] seen_q;
  logic                     tbl_we;
  logic [TABLE_AW-1:0]      tbl_waddr;
  logic                     tbl_wdata;

  logic [DATA_W-1:0] comp;
  logic              in_range;
  logic              hit;

  assign comp     = TARGET_W - data;
  assign in_range = (data <= TARGET_W);
  assign hit      = seen_q[comp[TABLE_AW-1:0]];

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    done_d       = done_q;
    found_d      = found_q;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    product_d    = product_q;
    beat_count_d = beat_count_q;
    tbl_we       = 1'b0;
    tbl_waddr    = clr_addr_q;
    tbl_wdata    = 1'b0;

    if (restart) begin
      state_d      = ST_CLEAR;
      clr_addr_d   = '0;
      done_d       = 1'b0;
      found_d      = 1'b0;
      operand_a_d  = '0;
      operand_b_d  = '0;
      product_d    = '0;
      beat_count_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          tbl_we     = 1'b1;
          clr_addr_d = clr_addr_q + TABLE_AW'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (data_valid) begin
            if (beat_count_q != 16'hFFFF) begin
              beat_count_d = beat_count_q + 16'd1;
            end
            // Lookup precedes insert, so a self-pair needs an earlier equal value.
            if (in_range && hit) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              found_d     = 1'b1;
              operand_a_d = comp;
              operand_b_d = data;
              product_d   = {{DATA_W{1'b0}}, comp} * {{DATA_W{1'b0}}, data};
            end else begin
              if (in_range) begin
                tbl_we    = 1'b1;
                tbl_waddr = data[TABLE_AW-1:0];
                tbl_wdata = 1'b1;
              end
              if (data_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      product_q    <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      done_q       <= done_d;
      found_q      <= found_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      product_q    <= product_d;
      beat_count_q <= beat_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tbl_we) begin
      seen_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign data_ready = (state_q == ST_RUN);
  assign done       = done_q;
  assign found      = found_q;
  assign operand_a  = operand_a_q;
  assign operand_b  = operand_b_q;
  assign product    = product_q;
  assign beat_count = beat_count_q;

endmodule
